// File: rtl/switch_pkg.sv
// Shared types and default timing constants for the push-button conditioning path.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEATING
    } hold_state_t;

    localparam int unsigned CLK_HZ = 25000000;

    // 10 ms debounce, 500 ms before auto-repeat, 100 ms repeat period.
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = CLK_HZ / 100;
    localparam int unsigned DEFAULT_HOLD_LIMIT     = CLK_HZ / 2;
    localparam int unsigned DEFAULT_REPEAT_LIMIT   = CLK_HZ / 10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a raw mechanical switch.
// o_Change flags that o_Switch flips on the next clock edge.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Change
);

    localparam int unsigned CW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [1:0]    sync_q;
    logic          s_sync;
    logic [CW-1:0] count_q, count_d;
    logic          switch_q;

    assign s_sync = sync_q[1];

    always_comb begin
        count_d  = '0;
        o_Change = 1'b0;
        if (s_sync != switch_q) begin
            if (count_q == COUNT_LAST) begin
                o_Change = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_q   <= 2'b00;
            count_q  <= '0;
            switch_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], i_Switch};
            count_q  <= count_d;
            switch_q <= switch_q ^ o_Change;
        end
    end

    assign o_Switch = switch_q;

endmodule

// File: rtl/switch_conditioner.sv
// Debounced switch level with press/release pulses and hold-to-repeat pulses,
// all registered so they line up with the debounced level.
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter int unsigned REPEAT_LIMIT   = DEFAULT_REPEAT_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Repeat,
    output logic o_Held
);

    localparam int unsigned TW = max_u($clog2(HOLD_LIMIT), $clog2(REPEAT_LIMIT));
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_LIMIT - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_LIMIT - 1);

    logic        deb_switch;
    logic        deb_change;
    logic        rise, fall;

    hold_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          repeat_d;
    logic          press_q, release_q, repeat_q, held_q;

    switch_debounce #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Switch(i_Switch),
        .o_Switch(deb_switch),
        .o_Change(deb_change)
    );

    // Acting on the pending change keeps pulses and FSM aligned with the new level.
    assign rise = deb_change & ~deb_switch;
    assign fall = deb_change & deb_switch;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        repeat_d = 1'b0;
        if (fall) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = PRESSED;
                        timer_d = '0;
                    end
                end
                PRESSED: begin
                    if (timer_q == HOLD_LAST) begin
                        repeat_d = 1'b1;
                        state_d  = REPEATING;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                REPEATING: begin
                    if (timer_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            press_q   <= rise;
            release_q <= fall;
            repeat_q  <= repeat_d;
            held_q    <= (state_d == REPEATING);
        end
    end

    assign o_Switch  = deb_switch;
    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_Repeat  = repeat_q;
    assign o_Held    = held_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: table of raw pulse widths plus reset sequences,
// each cycle's outputs checked against expectations queued at stimulus time.
module tb_switch_conditioner;

    typedef struct {
        int         cycle;
        logic [4:0] bits;   // {switch, press, release, repeat, held}
        string      name;
    } exp_t;

    typedef struct {
        int width;
        int repeats;
    } vec_t;

    logic clk;
    logic i_Reset;
    logic i_Switch;
    logic o_Switch, o_Press, o_Release, o_Repeat, o_Held;

    exp_t sb_q[$];
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   rep_total;

    switch_conditioner #(
        .DEBOUNCE_LIMIT(4),
        .HOLD_LIMIT    (10),
        .REPEAT_LIMIT  (3)
    ) dut (
        .i_Clk    (clk),
        .i_Reset  (i_Reset),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Repeat (o_Repeat),
        .o_Held   (o_Held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs in cycle k for a raw pulse high from cycle c0 for w cycles,
    // starting from a settled low state (DEBOUNCE 4, HOLD 10, REPEAT 3).
    function automatic logic [4:0] expected(input int c0, input int w, input int k);
        int t, f;
        logic sw, pr, rl, rp, hd;
        if (w < 4) return 5'b00000;
        t  = c0 + 6;
        f  = c0 + w + 6;
        sw = (k >= t) && (k < f);
        pr = (k == t);
        rl = (k == f);
        hd = (k >= t + 10) && (k < f);
        rp = hd && (((k - t - 10) % 3) == 0);
        return {sw, pr, rl, rp, hd};
    endfunction

    task automatic push_exp(input int k, input logic [4:0] bits, input string name);
        exp_t e;
        e.cycle = k;
        e.bits  = bits;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic push_pulse(input int c0, input int w, input int from, input int to,
                              input string name);
        for (int k = from; k <= to; k++) push_exp(k, expected(c0, w, k), name);
    endtask

    task automatic check_outputs();
        logic [4:0] got;
        exp_t e;
        got = {o_Switch, o_Press, o_Release, o_Repeat, o_Held};
        if (o_Repeat === 1'b1) rep_total++;
        while (sb_q.size() > 0 && sb_q[0].cycle <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.cycle != cyc || got !== e.bits) begin
                n_err++;
                $display("FAIL %s cycle %0d (now %0d): sw/pr/rl/rp/hd got %b, want %b",
                         e.name, e.cycle, cyc, got, e.bits);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations still pending, want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reps(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s repeat count: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        vec_t vecs[10];
        int   c0;
        int   rep0;
        string nm;

        vecs = '{'{1, 0}, '{3, 0}, '{4, 0}, '{5, 0}, '{9, 0},
                 '{10, 0}, '{11, 1}, '{13, 1}, '{16, 2}, '{30, 7}};
        n_cmp     = 0;
        n_err     = 0;
        rep_total = 0;
        i_Reset   = 1'b1;
        i_Switch  = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;

        // Reset held while the raw input toggles.
        for (int i = 0; i < 5; i++) begin
            i_Switch = (i % 2) == 1;
            push_exp(cyc, 5'b00000, "reset_hold");
            tick();
        end
        i_Reset  = 1'b0;
        i_Switch = 1'b0;
        for (int k = cyc; k < cyc + 5; k++) push_exp(k, 5'b00000, "after_reset");
        drain();

        // Single raw pulses of various widths.
        foreach (vecs[v]) begin
            nm = $sformatf("pulse_w%0d", vecs[v].width);
            c0 = cyc;
            rep0 = rep_total;
            i_Switch = 1'b1;
            push_pulse(c0, vecs[v].width, c0, c0 + vecs[v].width + 10, nm);
            repeat (vecs[v].width) tick();
            i_Switch = 1'b0;
            drain();
            check_reps(nm, rep_total - rep0, vecs[v].repeats);
        end

        // Reset while repeating with the switch held, then a fresh press after deassert.
        c0 = cyc;
        rep0 = rep_total;
        i_Switch = 1'b1;
        push_pulse(c0, 1000, c0, c0 + 18, "rst_repeating");
        push_exp(c0 + 19, 5'b00000, "rst_cleared");
        push_exp(c0 + 20, 5'b00000, "rst_cleared");
        push_pulse(c0 + 20, 8, c0 + 21, c0 + 38, "after_rst_press");
        repeat (18) tick();
        i_Reset = 1'b1;
        repeat (2) tick();
        i_Reset = 1'b0;
        repeat (8) tick();
        i_Switch = 1'b0;
        drain();
        check_reps("rst_repeating", rep_total - rep0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
